execute_writeback: RTL
======================

// Module: execute_writeback
// PURPOSE
// - Consumer side of the execute-stage result interface: accepts one completed command per handshake and commits it.
// - Writes up to two GPR results (EDX:EAX for MUL/IMUL/DIV/IDIV) to the register file write port.
// - Merges new flag bits into the architectural EFLAGS register.
// - Drives EFLAGS back to execute and counts retired commands.
// PARAMETERS
// - EFLAGS_RST  32'h0000_0002  EFLAGS reset value; bit 1 is reserved-one.
// - CNT_W       32             width of the retired-command counter.
// PORTS
// - clk            in   1   sole clock; all state updates on posedge.
// - rst            in   1   asynchronous, active-high reset.
// - ex_valid       in   1   execute presents a result.
// - ex_ready       out  1   writeback can capture a result.
// - ex_opc         in   6   command code (CMD_* encoding).
// - ex_no_wr       in   1   suppress GPR writes (CMP/CMPS); flags still commit.
// - ex_dst0        in   3   GPR index for ex_res0.
// - ex_res0        in   32  primary result.
// - ex_dst1_en     in   1   a second GPR write follows.
// - ex_dst1        in   3   GPR index for ex_res1.
// - ex_res1        in   32  secondary result (high half / remainder).
// - ex_flags       in   32  flag values computed by the ALU.
// - ex_flags_mask  in   32  1 = the command updates this EFLAGS bit.
// - flush          in   1   drop the result offered in this cycle.
// - rf_we          out  1   register-file write strobe.
// - rf_waddr       out  3   register-file write index.
// - rf_wdata       out  32  register-file write data.
// - eflags         out  32  architectural EFLAGS, fed to execute.
// - retire         out  1   one-cycle pulse when a command commits.
// - retire_cnt     out  CNT_W  count of committed commands.
// BEHAVIOUR
// - Reset values (async): state=IDLE; ex_ready=1; rf_we=0; rf_waddr=0; rf_wdata=0;
//   eflags=EFLAGS_RST; retire=0; retire_cnt=0. Reset mid-command abandons it; no partial commit survives.
// - FSM states and transitions:
//   - IDLE: ex_ready=1.
//     - ex_valid & ~flush: capture all ex_* fields into holding registers; go to WR0.
//     - ex_valid & flush: no capture, no retire; stay in IDLE.
//   - WR0: rf_we=~no_wr_q; rf_waddr=dst0_q; rf_wdata=res0_q.
//     - dst1_en_q & ~no_wr_q: go to WR1.
//     - otherwise: COMMIT in this cycle, then go to IDLE.
//   - WR1: rf_we=1; rf_waddr=dst1_q; rf_wdata=res1_q; COMMIT in this cycle; go to IDLE.
//   - no_wr_q overrides dst1_en_q: a CMP never writes and never enters WR1.
// - Outputs are combinational from state and holding registers; ex_ready=0 outside IDLE.
// - COMMIT, taking effect at the end of the commit cycle:
//   - eflags <= ((eflags & ~mask_q) | (flags_q & mask_q)) with bit1 forced 1 and bits 3, 5, 15 forced 0.
//   - retire=1; retire_cnt increments and wraps from all-ones to 0.
// - Latency:
//   - single-write command: capture at cycle 0; GPR write and flag commit at cycle 1; new eflags visible at cycle 2.
//   - dual-write command: writes at cycles 1 and 2; new eflags visible at cycle 3.
// - Throughput: one command per 2 cycles (single write) or 3 cycles (dual write); ex_ready returns only in IDLE.
// - flush is sampled in IDLE only; it is ignored in WR0 and WR1 because commit is atomic once the result is captured.
// - Holding registers are loaded only on capture; ex_* changes after capture have no effect.
// STRUCTURE
// - CMD_* opcodes come from the generated commands header.
// - FSM state encodings and the EFLAGS reserved-bit masks go in the shared funcs/package include.
// - One sub-module: eflags_merge, combinational (old, new, mask) -> merged value with reserved bits fixed.
// - FSM, holding registers and retire counter live in the top module.
// TESTING
// - ADD: dst0=0, res0=32'h5, mask=32'h8D5, flags=32'h40.
//   -> cycle 1: rf_we=1, waddr=0, wdata=5, retire=1; cycle 2: eflags=32'h42, retire_cnt=1.
// - MUL: dst0=0 (EAX), res0=32'hDEAD, dst1_en=1, dst1=2 (EDX), res1=32'hBEEF.
//   -> writes EAX=DEAD at cycle 1, EDX=BEEF at cycle 2; single retire pulse at cycle 2.
// - CMP: no_wr=1, dst1_en=1, flags=32'h1, mask=32'h1.
//   -> rf_we stays 0 throughout; eflags bit0=1 at cycle 2; retire_cnt+1.
// - flush together with ex_valid in IDLE.
//   -> no write, no retire, eflags unchanged; ex_ready stays 1.
// - flush asserted during WR0.
//   -> command completes normally.
// - Assert rst during WR1 of a MUL.
//   -> immediately eflags=32'h2, retire_cnt=0, rf_we=0, ex_ready=1.
// - Preload retire_cnt to all-ones, retire one command.
//   -> retire_cnt=0.
// - Flags with bits 3, 5, 15 set and mask=32'hFFFF_FFFF.
//   -> eflags bits 3, 5, 15 = 0 and bit 1 = 1.

Source files
------------

// File: rtl/execute_writeback_pkg.sv
// Shared definitions for the execute-stage writeback block: command codes,
// FSM state encoding, EFLAGS reserved-bit masks and the captured-command record.
package execute_writeback_pkg;

    // Command codes (CMD_* encoding shared with decode/execute)
    localparam logic [5:0] CMD_ADD  = 6'h00;
    localparam logic [5:0] CMD_SUB  = 6'h01;
    localparam logic [5:0] CMD_AND  = 6'h02;
    localparam logic [5:0] CMD_OR   = 6'h03;
    localparam logic [5:0] CMD_XOR  = 6'h04;
    localparam logic [5:0] CMD_CMP  = 6'h05;
    localparam logic [5:0] CMD_CMPS = 6'h06;
    localparam logic [5:0] CMD_MUL  = 6'h10;
    localparam logic [5:0] CMD_IMUL = 6'h11;
    localparam logic [5:0] CMD_DIV  = 6'h12;
    localparam logic [5:0] CMD_IDIV = 6'h13;

    // Writeback FSM: wait for a result, write primary GPR, write secondary GPR
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR0  = 2'd1,
        ST_WR1  = 2'd2
    } wb_state_e;

    // EFLAGS bits whose value is architecturally fixed
    localparam logic [31:0] EFLAGS_RSVD_ONE  = 32'h0000_0002;  // bit 1
    localparam logic [31:0] EFLAGS_RSVD_ZERO = 32'h0000_8028;  // bits 3, 5, 15

    // Everything execute hands over, held for the whole commit sequence
    typedef struct packed {
        logic [5:0]  opc;
        logic        no_wr;
        logic [2:0]  dst0;
        logic [31:0] res0;
        logic        dst1_en;
        logic [2:0]  dst1;
        logic [31:0] res1;
        logic [31:0] flags;
        logic [31:0] mask;
    } wb_cmd_t;

    // Force the reserved EFLAGS bits to their fixed values
    function automatic logic [31:0] fix_reserved(input logic [31:0] value);
        return (value | EFLAGS_RSVD_ONE) & ~EFLAGS_RSVD_ZERO;
    endfunction

endpackage

// File: rtl/execute_writeback_eflags_merge.sv
// Combinational EFLAGS merge: bits selected by mask come from the new flags,
// the rest keep their old value, then reserved bits are pinned.
module execute_writeback_eflags_merge
    import execute_writeback_pkg::*;
(
    input  logic [31:0] old_flags,
    input  logic [31:0] new_flags,
    input  logic [31:0] mask,
    output logic [31:0] merged
);

    assign merged = fix_reserved((old_flags & ~mask) | (new_flags & mask));

endmodule

// File: rtl/execute_writeback.sv
// Execute-stage writeback: captures one result per handshake, writes up to two
// GPRs, merges flags into EFLAGS atomically and counts retired commands.
module execute_writeback
    import execute_writeback_pkg::*;
#(
    parameter logic [31:0] EFLAGS_RST = 32'h0000_0002,
    parameter int          CNT_W      = 32
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_valid,
    output logic             ex_ready,
    input  logic [5:0]       ex_opc,
    input  logic             ex_no_wr,
    input  logic [2:0]       ex_dst0,
    input  logic [31:0]      ex_res0,
    input  logic             ex_dst1_en,
    input  logic [2:0]       ex_dst1,
    input  logic [31:0]      ex_res1,
    input  logic [31:0]      ex_flags,
    input  logic [31:0]      ex_flags_mask,
    input  logic             flush,
    output logic             rf_we,
    output logic [2:0]       rf_waddr,
    output logic [31:0]      rf_wdata,
    output logic [31:0]      eflags,
    output logic             retire,
    output logic [CNT_W-1:0] retire_cnt
);

    wb_state_e        state_q, state_d;
    wb_cmd_t          cmd_q, cmd_d;
    logic [31:0]      eflags_q, eflags_d;
    logic [CNT_W-1:0] retire_cnt_q, retire_cnt_d;
    logic             commit;
    logic [31:0]      eflags_merged;

    // The opcode is held with the rest of the command but no commit step depends on it
    logic unused_opc;
    assign unused_opc = ^cmd_q.opc;

    execute_writeback_eflags_merge u_eflags_merge (
        .old_flags (eflags_q),
        .new_flags (cmd_q.flags),
        .mask      (cmd_q.mask),
        .merged    (eflags_merged)
    );

    // Next-state, capture and register-file outputs from state and holding registers
    always_comb begin
        // NOTE: every output gets a default before the case so no path can infer a latch.
        state_d  = state_q;
        cmd_d    = cmd_q;
        ex_ready = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = 3'd0;
        rf_wdata = 32'd0;
        commit   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                ex_ready = 1'b1;
                // flush only matters here; once captured the command commits atomically
                if (ex_valid && !flush) begin
                    cmd_d = '{
                        opc:     ex_opc,
                        no_wr:   ex_no_wr,
                        dst0:    ex_dst0,
                        res0:    ex_res0,
                        dst1_en: ex_dst1_en,
                        dst1:    ex_dst1,
                        res1:    ex_res1,
                        flags:   ex_flags,
                        mask:    ex_flags_mask
                    };
                    state_d = ST_WR0;
                end
            end
            ST_WR0: begin
                rf_we    = ~cmd_q.no_wr;
                rf_waddr = cmd_q.dst0;
                rf_wdata = cmd_q.res0;
                // A no-write command (CMP) never takes the second write slot
                if (cmd_q.dst1_en && !cmd_q.no_wr) begin
                    state_d = ST_WR1;
                end else begin
                    commit  = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_WR1: begin
                rf_we    = 1'b1;
                rf_waddr = cmd_q.dst1;
                rf_wdata = cmd_q.res1;
                commit   = 1'b1;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Architectural flags and retire count change only in the commit cycle
    always_comb begin
        eflags_d     = eflags_q;
        retire_cnt_d = retire_cnt_q;
        if (commit) begin
            eflags_d     = eflags_merged;
            retire_cnt_d = retire_cnt_q + CNT_W'(1);
        end
    end

    // State, holding registers, EFLAGS and retire counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            cmd_q        <= '0;
            eflags_q     <= EFLAGS_RST;
            retire_cnt_q <= '0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values, independent of statement order.
            state_q      <= state_d;
            cmd_q        <= cmd_d;
            eflags_q     <= eflags_d;
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign eflags     = eflags_q;
    assign retire     = commit;
    assign retire_cnt = retire_cnt_q;

endmodule
